// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one full-adder cell.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, borrow_q, borrow_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             nb, s, cout;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  // Single full-adder cell on a and ~b; carry preset to 1 completes the two's complement.
  assign nb   = ~b_sh_q[0];
  assign s    = a_sh_q[0] ^ nb ^ carry_q;
  assign cout = (a_sh_q[0] & nb) | (carry_q & (a_sh_q[0] ^ nb));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {s, res_q[WIDTH-1:1]};
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d   = {s, res_q[WIDTH-1:1]};
          borrow_d = ~cout;
          state_d  = DONE;
`ifdef SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) & (s != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SUB_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands against an
// arithmetic reference model, plus ignored start, back-to-back and mid-run reset scenarios.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int NB2B  = 5;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [WIDTH-1:0] a, b, diff;
  logic             busy, done, borrow;
`ifdef SUB_OVERFLOW_EN
  logic             overflow;
`endif

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular and signed integer arithmetic.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return x - y;
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    return (d > (2 ** (WIDTH - 1)) - 1) || (d < -(2 ** (WIDTH - 1)));
  endfunction

  task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/diff"}, 32'(diff), 32'(ref_diff(x, y)));
    check({tag, "/borrow"}, 32'(borrow), 32'(ref_borrow(x, y)));
`ifdef SUB_OVERFLOW_EN
    check({tag, "/overflow"}, 32'(overflow), 32'(ref_ovf(x, y)));
`endif
    last_diff = ref_diff(x, y);
  endtask

  // Waits from just after an accept edge until done; returns edges counted including the accept edge.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 3 * WIDTH) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string tag);
    int edges;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    check({tag, "/busy"}, 32'(busy), 32'd1);
    check({tag, "/diff_held"}, 32'(diff), 32'(last_diff));
    wait_done(edges);
    check({tag, "/latency"}, 32'(edges), 32'(WIDTH + 1));
    check_result(tag, x, y);
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int edges, pulses;
    logic [WIDTH-1:0] opa [NB2B];
    logic [WIDTH-1:0] opb [NB2B];

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/diff", 32'(diff), 32'd0);
    check("reset/borrow", 32'(borrow), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("reset/overflow", 32'(overflow), 32'd0);
`endif
    reset = 1'b0;

    run_op(8'd10, 8'd3, "10-3");
    run_op(8'd3, 8'd10, "3-10");
    run_op(8'h5A, 8'h5A, "eq");
    run_op(8'h80, 8'h01, "80-01");
    run_op(8'h01, 8'h02, "01-02");
    run_op(8'hC3, 8'h00, "b_zero");
    run_op(8'h00, 8'h01, "0-1");
    run_op(8'h7F, 8'hFF, "7F-FF");
    for (int i = 0; i < 20; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), $sformatf("rand%0d", i));

    // start pulsed during the third RUN cycle must be ignored.
    @(negedge clk);
    a = 8'd20; b = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = '0; b = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("ignore/pulses", 32'(pulses), 32'd1);
    check("ignore/diff", 32'(diff), 32'd15);
    check("ignore/borrow", 32'(borrow), 32'd0);
    last_diff = 8'd15;

    // Back-to-back: start held high, new operands presented in every DONE cycle.
    for (int i = 0; i < NB2B; i++) begin
      opa[i] = WIDTH'($urandom);
      opb[i] = WIDTH'($urandom);
    end
    @(negedge clk);
    a = opa[0]; b = opb[0]; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NB2B; k++) begin
      @(negedge clk);
      wait_done(edges);
      check($sformatf("b2b%0d/period", k), 32'(edges), 32'(WIDTH + 1));
      check_result($sformatf("b2b%0d", k), opa[k], opb[k]);
      if (k < NB2B - 1) begin
        a = opa[k+1];
        b = opb[k+1];
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("b2b/idle_done", 32'(done), 32'd0);
    check("b2b/idle_busy", 32'(busy), 32'd0);

    // Reset between edges mid-RUN aborts the operation immediately.
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/diff", 32'(diff), 32'd0);
    check("abort/borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("abort/no_done", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
